id_ex_stage: RTL and testbench

ID/EX pipeline register and EX-stage operand selector. It sits directly upstream of the ALU. Each cycle it captures decoded operands and controls from ID. It resolves data hazards by forwarding from EX/MEM and MEM/WB, then drives the ALU's A, B, ALUFun and Sign inputs. It also passes store data, destination register and MEM/WB controls downstream, and flags load-use hazards to the hazard unit.

---
 rtl/id_ex_stage_if.sv | 72 +++++++
 rtl/id_ex_stage.sv | 153 +++++++++++++++
 tb/tb_id_ex_stage.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/id_ex_stage_if.sv
// ID/EX stage bus: ID-side decoded fields, stall/flush, the EX/MEM and
// MEM/WB forwarding taps, and the EX-side outputs toward ALU and MEM.
interface id_ex_stage_if #(
    parameter int WIDTH    = 32,
    parameter int REG_BITS = 5
);
    // pipeline control
    logic                stall;
    logic                flush;

    // from ID
    logic [WIDTH-1:0]    id_rs_data;
    logic [WIDTH-1:0]    id_rt_data;
    logic [WIDTH-1:0]    id_imm;
    logic [4:0]          id_shamt;
    logic [REG_BITS-1:0] id_rs;
    logic [REG_BITS-1:0] id_rt;
    logic [REG_BITS-1:0] id_dst;
    logic                id_alu_src1;
    logic                id_alu_src2;
    logic [5:0]          id_alu_fun;
    logic                id_sign;
    logic                id_reg_write;
    logic                id_mem_read;
    logic                id_mem_write;
    logic [1:0]          id_mem_to_reg;
    logic [WIDTH-1:0]    id_pc_plus4;

    // forwarding taps
    logic                exm_reg_write;
    logic [REG_BITS-1:0] exm_dst;
    logic [WIDTH-1:0]    exm_result;
    logic                wb_reg_write;
    logic [REG_BITS-1:0] wb_dst;
    logic [WIDTH-1:0]    wb_result;

    // to EX / downstream
    logic [WIDTH-1:0]    alu_a;
    logic [WIDTH-1:0]    alu_b;
    logic [5:0]          alu_fun;
    logic                alu_sign;
    logic [WIDTH-1:0]    ex_store_data;
    logic [REG_BITS-1:0] ex_dst;
    logic                ex_reg_write;
    logic                ex_mem_read;
    logic                ex_mem_write;
    logic [1:0]          ex_mem_to_reg;
    logic [WIDTH-1:0]    ex_pc_plus4;
    logic                load_use_hazard;

    modport master (
        output stall, flush,
        output id_rs_data, id_rt_data, id_imm, id_shamt, id_rs, id_rt, id_dst,
        output id_alu_src1, id_alu_src2, id_alu_fun, id_sign,
        output id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg, id_pc_plus4,
        output exm_reg_write, exm_dst, exm_result, wb_reg_write, wb_dst, wb_result,
        input  alu_a, alu_b, alu_fun, alu_sign, ex_store_data, ex_dst,
        input  ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_pc_plus4,
        input  load_use_hazard
    );

    modport slave (
        input  stall, flush,
        input  id_rs_data, id_rt_data, id_imm, id_shamt, id_rs, id_rt, id_dst,
        input  id_alu_src1, id_alu_src2, id_alu_fun, id_sign,
        input  id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg, id_pc_plus4,
        input  exm_reg_write, exm_dst, exm_result, wb_reg_write, wb_dst, wb_result,
        output alu_a, alu_b, alu_fun, alu_sign, ex_store_data, ex_dst,
        output ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_pc_plus4,
        output load_use_hazard
    );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with EX-stage operand forwarding and
// load-use hazard detection. One forwarding lane per source operand.

// Per-operand forwarding mux: EX/MEM beats MEM/WB, r0 is never forwarded.
module id_ex_fwd #(
    parameter int WIDTH    = 32,
    parameter int REG_BITS = 5
) (
    input  logic [REG_BITS-1:0] src_i,
    input  logic [WIDTH-1:0]    reg_data_i,
    input  logic                exm_reg_write_i,
    input  logic [REG_BITS-1:0] exm_dst_i,
    input  logic [WIDTH-1:0]    exm_result_i,
    input  logic                wb_reg_write_i,
    input  logic [REG_BITS-1:0] wb_dst_i,
    input  logic [WIDTH-1:0]    wb_result_i,
    output logic [WIDTH-1:0]    fwd_o
);
    logic exm_hit;
    logic wb_hit;

    assign exm_hit = exm_reg_write_i && (exm_dst_i != '0) && (exm_dst_i == src_i);
    assign wb_hit  = wb_reg_write_i  && (wb_dst_i  != '0) && (wb_dst_i  == src_i);

    // Select the youngest in-flight producer of this operand.
    always_comb begin
        fwd_o = reg_data_i;
        if (exm_hit)
            fwd_o = exm_result_i;
        else if (wb_hit)
            fwd_o = wb_result_i;
    end
endmodule

module id_ex_stage #(
    parameter int WIDTH    = 32,
    parameter int REG_BITS = 5
) (
    input logic         clk,
    input logic         reset,
    id_ex_stage_if.slave bus
);
    localparam int NUM_OPS = 2;   // lane 0 = rs, lane 1 = rt

    typedef struct packed {
        logic [WIDTH-1:0]    rs_data;
        logic [WIDTH-1:0]    rt_data;
        logic [WIDTH-1:0]    imm;
        logic [WIDTH-1:0]    pc_plus4;
        logic [4:0]          shamt;
        logic [REG_BITS-1:0] rs;
        logic [REG_BITS-1:0] rt;
        logic [REG_BITS-1:0] dst;
        logic                alu_src1;
        logic                alu_src2;
        logic [5:0]          alu_fun;
        logic                sign;
        logic                reg_write;
        logic                mem_read;
        logic                mem_write;
        logic [1:0]          mem_to_reg;
    } idex_t;

    idex_t id_in;
    idex_t ex_d;
    idex_t ex_q;

    // Gather ID-side fields into one record for capture.
    always_comb begin
        id_in            = '0;
        id_in.rs_data    = bus.id_rs_data;
        id_in.rt_data    = bus.id_rt_data;
        id_in.imm        = bus.id_imm;
        id_in.pc_plus4   = bus.id_pc_plus4;
        id_in.shamt      = bus.id_shamt;
        id_in.rs         = bus.id_rs;
        id_in.rt         = bus.id_rt;
        id_in.dst        = bus.id_dst;
        id_in.alu_src1   = bus.id_alu_src1;
        id_in.alu_src2   = bus.id_alu_src2;
        id_in.alu_fun    = bus.id_alu_fun;
        id_in.sign       = bus.id_sign;
        id_in.reg_write  = bus.id_reg_write;
        id_in.mem_read   = bus.id_mem_read;
        id_in.mem_write  = bus.id_mem_write;
        id_in.mem_to_reg = bus.id_mem_to_reg;
    end

    // Next state: flush loads an all-zero bubble (ADD to r0, no side effects),
    // stall holds, otherwise capture.
    always_comb begin
        ex_d = ex_q;
        if (bus.flush)
            ex_d = '0;
        else if (!bus.stall)
            ex_d = id_in;
    end

    // Pipeline register; reset wins over flush and stall.
    always_ff @(posedge clk) begin
        if (reset)
            ex_q <= '0;
        else
            ex_q <= ex_d;
    end

    logic [NUM_OPS-1:0][REG_BITS-1:0] src_q;
    logic [NUM_OPS-1:0][WIDTH-1:0]    data_q;
    logic [NUM_OPS-1:0][WIDTH-1:0]    fwd;

    assign src_q[0]  = ex_q.rs;
    assign src_q[1]  = ex_q.rt;
    assign data_q[0] = ex_q.rs_data;
    assign data_q[1] = ex_q.rt_data;

    generate
        for (genvar g = 0; g < NUM_OPS; g++) begin : g_fwd
            id_ex_fwd #(
                .WIDTH    (WIDTH),
                .REG_BITS (REG_BITS)
            ) u_fwd (
                .src_i           (src_q[g]),
                .reg_data_i      (data_q[g]),
                .exm_reg_write_i (bus.exm_reg_write),
                .exm_dst_i       (bus.exm_dst),
                .exm_result_i    (bus.exm_result),
                .wb_reg_write_i  (bus.wb_reg_write),
                .wb_dst_i        (bus.wb_dst),
                .wb_result_i     (bus.wb_result),
                .fwd_o           (fwd[g])
            );
        end
    endgenerate

    // Operand select; store data always takes the forwarded rt even when B is imm.
    assign bus.alu_a         = ex_q.alu_src1 ? {{(WIDTH-5){1'b0}}, ex_q.shamt} : fwd[0];
    assign bus.alu_b         = ex_q.alu_src2 ? ex_q.imm : fwd[1];
    assign bus.ex_store_data = fwd[1];

    // Controls pass straight from the register.
    assign bus.alu_fun       = ex_q.alu_fun;
    assign bus.alu_sign      = ex_q.sign;
    assign bus.ex_dst        = ex_q.dst;
    assign bus.ex_reg_write  = ex_q.reg_write;
    assign bus.ex_mem_read   = ex_q.mem_read;
    assign bus.ex_mem_write  = ex_q.mem_write;
    assign bus.ex_mem_to_reg = ex_q.mem_to_reg;
    assign bus.ex_pc_plus4   = ex_q.pc_plus4;

    // A load in EX whose destination feeds the instruction now in ID.
    assign bus.load_use_hazard = ex_q.mem_read && (ex_q.dst != '0) &&
                                 ((ex_q.dst == bus.id_rs) || (ex_q.dst == bus.id_rt));
endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: expected EX-side views are queued as
// stimulus is driven and popped when the stage output is sampled.
module tb_id_ex_stage;
    localparam int W  = 32;
    localparam int RB = 5;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    id_ex_stage_if #(.WIDTH(W), .REG_BITS(RB)) bus();

    id_ex_stage #(.WIDTH(W), .REG_BITS(RB)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] st;
        logic [5:0]  fun;
        logic [4:0]  dst;
        logic        rw;
        logic        mr;
        logic        hz;
    } exp_t;

    exp_t sb[$];
    exp_t e, o;
    int   total = 0;
    int   bad   = 0;

    function automatic exp_t mk(input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] st, input logic [5:0] fun,
                                input logic [4:0] dst, input logic rw,
                                input logic mr, input logic hz);
        exp_t r;
        r.a = a; r.b = b; r.st = st; r.fun = fun; r.dst = dst;
        r.rw = rw; r.mr = mr; r.hz = hz;
        return r;
    endfunction

    function automatic exp_t obs();
        exp_t r;
        r.a = bus.alu_a; r.b = bus.alu_b; r.st = bus.ex_store_data;
        r.fun = bus.alu_fun; r.dst = bus.ex_dst; r.rw = bus.ex_reg_write;
        r.mr = bus.ex_mem_read; r.hz = bus.load_use_hazard;
        return r;
    endfunction

    function automatic string fmt(input exp_t r);
        return $sformatf("a=%h b=%h st=%h fun=%b dst=%0d rw=%b mr=%b hz=%b",
                         r.a, r.b, r.st, r.fun, r.dst, r.rw, r.mr, r.hz);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic id_zero();
        bus.stall = 1'b0;        bus.flush = 1'b0;
        bus.id_rs_data = '0;     bus.id_rt_data = '0;   bus.id_imm = '0;
        bus.id_shamt = '0;       bus.id_rs = '0;        bus.id_rt = '0;
        bus.id_dst = '0;         bus.id_alu_src1 = 1'b0; bus.id_alu_src2 = 1'b0;
        bus.id_alu_fun = '0;     bus.id_sign = 1'b0;    bus.id_reg_write = 1'b0;
        bus.id_mem_read = 1'b0;  bus.id_mem_write = 1'b0; bus.id_mem_to_reg = '0;
        bus.id_pc_plus4 = '0;
        bus.exm_reg_write = 1'b0; bus.exm_dst = '0; bus.exm_result = '0;
        bus.wb_reg_write = 1'b0;  bus.wb_dst = '0;  bus.wb_result = '0;
    endtask

    task automatic test_reset();
        id_zero();
        bus.id_rs_data = 32'hDEAD_BEEF; bus.id_rt_data = 32'h1234_5678;
        bus.id_imm = 32'h0000_00FF; bus.id_alu_fun = 6'h3F; bus.id_reg_write = 1'b1;
        bus.id_mem_read = 1'b1; bus.id_dst = 5'd7; bus.id_rs = 5'd3; bus.id_rt = 5'd4;
        bus.id_pc_plus4 = 32'h400; bus.id_mem_to_reg = 2'd3;
        reset = 1'b1;
        sb.push_back(mk(32'd0, 32'd0, 32'd0, 6'd0, 5'd0, 1'b0, 1'b0, 1'b0));
        tick(); tick();
        e = sb.pop_front(); o = obs(); total++;
        if (o !== e) begin bad++; $display("FAIL reset: got %s want %s", fmt(o), fmt(e)); end
        total++;
        if ({bus.ex_mem_to_reg, bus.ex_pc_plus4, bus.alu_sign, bus.ex_mem_write} !== 36'd0) begin
            bad++;
            $display("FAIL reset_misc: got m2r=%0d pc4=%h sign=%b mw=%b want all 0",
                     bus.ex_mem_to_reg, bus.ex_pc_plus4, bus.alu_sign, bus.ex_mem_write);
        end
        reset = 1'b0;
    endtask

    task automatic test_capture();
        id_zero();
        bus.id_rs = 5'd1; bus.id_rt = 5'd2; bus.id_rs_data = 32'd10; bus.id_rt_data = 32'd3;
        bus.id_alu_fun = 6'b000001; bus.id_reg_write = 1'b1; bus.id_dst = 5'd4;
        bus.id_mem_to_reg = 2'd2; bus.id_pc_plus4 = 32'h104;
        sb.push_back(mk(32'd10, 32'd3, 32'd3, 6'b000001, 5'd4, 1'b1, 1'b0, 1'b0));
        tick();
        e = sb.pop_front(); o = obs(); total++;
        if (o !== e) begin bad++; $display("FAIL capture: got %s want %s", fmt(o), fmt(e)); end
        total++;
        if (bus.ex_mem_to_reg !== 2'd2 || bus.ex_pc_plus4 !== 32'h104) begin
            bad++;
            $display("FAIL capture_pass: got m2r=%0d pc4=%h want m2r=2 pc4=00000104",
                     bus.ex_mem_to_reg, bus.ex_pc_plus4);
        end
    endtask

    task automatic test_fwd_priority();
        id_zero();
        bus.id_rs = 5'd5; bus.id_rs_data = 32'd7; bus.id_rt = 5'd6; bus.id_rt_data = 32'd9;
        bus.id_dst = 5'd1;
        tick();
        bus.exm_reg_write = 1'b1; bus.exm_dst = 5'd5; bus.exm_result = 32'd100;
        bus.wb_reg_write = 1'b1;  bus.wb_dst = 5'd5;  bus.wb_result = 32'd200;
        sb.push_back(mk(32'd100, 32'd9, 32'd9, 6'd0, 5'd1, 1'b0, 1'b0, 1'b0));
        #1; e = sb.pop_front(); o = obs(); total++;
        if (o !== e) begin bad++; $display("FAIL fwd_exm_first: got %s want %s", fmt(o), fmt(e)); end
        bus.exm_reg_write = 1'b0;
        sb.push_back(mk(32'd200, 32'd9, 32'd9, 6'd0, 5'd1, 1'b0, 1'b0, 1'b0));
        #1; e = sb.pop_front(); o = obs(); total++;
        if (o !== e) begin bad++; $display("FAIL fwd_wb: got %s want %s", fmt(o), fmt(e)); end
        bus.wb_reg_write = 1'b0;
        sb.push_back(mk(32'd7, 32'd9, 32'd9, 6'd0, 5'd1, 1'b0, 1'b0, 1'b0));
        #1; e = sb.pop_front(); o = obs(); total++;
        if (o !== e) begin bad++; $display("FAIL fwd_none: got %s want %s", fmt(o), fmt(e)); end
        bus.wb_reg_write = 1'b1; bus.wb_dst = 5'd6;
        sb.push_back(mk(32'd7, 32'd200, 32'd200, 6'd0, 5'd1, 1'b0, 1'b0, 1'b0));
        #1; e = sb.pop_front(); o = obs(); total++;
        if (o !== e) begin bad++; $display("FAIL fwd_rt_wb: got %s want %s", fmt(o), fmt(e)); end
        bus.exm_reg_write = 1'b1; bus.exm_dst = 5'd6;
        sb.push_back(mk(32'd7, 32'd100, 32'd100, 6'd0, 5'd1, 1'b0, 1'b0, 1'b0));
        #1; e = sb.pop_front(); o = obs(); total++;
        if (o !== e) begin bad++; $display("FAIL fwd_rt_exm: got %s want %s", fmt(o), fmt(e)); end
        // register 0 must never be forwarded
        id_zero();
        bus.id_rs_data = 32'h33; bus.id_rt_data = 32'h44;
        tick();
        bus.exm_reg_write = 1'b1; bus.exm_dst = 5'd0; bus.exm_result = 32'd100;
        bus.wb_reg_write = 1'b1;  bus.wb_dst = 5'd0;  bus.wb_result = 32'd200;
        sb.push_back(mk(32'h33, 32'h44, 32'h44, 6'd0, 5'd0, 1'b0, 1'b0, 1'b0));
        #1; e = sb.pop_front(); o = obs(); total++;
        if (o !== e) begin bad++; $display("FAIL fwd_r0: got %s want %s", fmt(o), fmt(e)); end
    endtask

    task automatic test_shamt_imm();
        id_zero();
        bus.id_rs = 5'd7; bus.id_rs_data = 32'h99; bus.id_rt = 5'd9; bus.id_rt_data = 32'h11;
        bus.id_alu_src1 = 1'b1; bus.id_shamt = 5'd3; bus.id_alu_src2 = 1'b1;
        bus.id_imm = 32'hFFFF_FFFF; bus.id_alu_fun = 6'b100011; bus.id_sign = 1'b1;
        bus.id_dst = 5'd2; bus.id_reg_write = 1'b1;
        tick();
        bus.exm_reg_write = 1'b1; bus.exm_dst = 5'd9; bus.exm_result = 32'h55;
        sb.push_back(mk(32'd3, 32'hFFFF_FFFF, 32'h55, 6'b100011, 5'd2, 1'b1, 1'b0, 1'b0));
        #1; e = sb.pop_front(); o = obs(); total++;
        if (o !== e) begin bad++; $display("FAIL shamt_imm: got %s want %s", fmt(o), fmt(e)); end
        total++;
        if (bus.alu_sign !== 1'b1) begin
            bad++; $display("FAIL sign: got %b want 1", bus.alu_sign);
        end
    endtask

    task automatic test_load_use();
        id_zero();
        bus.id_rs = 5'd1; bus.id_rt = 5'd2; bus.id_dst = 5'd8; bus.id_mem_read = 1'b1;
        bus.id_reg_write = 1'b1; bus.id_mem_to_reg = 2'd1; bus.id_rs_data = 32'h10;
        bus.id_imm = 32'd4; bus.id_alu_src2 = 1'b1;
        tick();
        bus.id_rs = 5'd3; bus.id_rt = 5'd8;
        sb.push_back(mk(32'h10, 32'd4, 32'd0, 6'd0, 5'd8, 1'b1, 1'b1, 1'b1));
        #1; e = sb.pop_front(); o = obs(); total++;
        if (o !== e) begin bad++; $display("FAIL lu_rt: got %s want %s", fmt(o), fmt(e)); end
        bus.flush = 1'b1;
        sb.push_back(mk(32'd0, 32'd0, 32'd0, 6'd0, 5'd0, 1'b0, 1'b0, 1'b0));
        tick();
        bus.flush = 1'b0;
        e = sb.pop_front(); o = obs(); total++;
        if (o !== e) begin bad++; $display("FAIL lu_flush: got %s want %s", fmt(o), fmt(e)); end
        // match on rs
        id_zero();
        bus.id_dst = 5'd8; bus.id_mem_read = 1'b1;
        tick();
        bus.id_rs = 5'd8; bus.id_rt = 5'd0;
        sb.push_back(mk(32'd0, 32'd0, 32'd0, 6'd0, 5'd8, 1'b0, 1'b1, 1'b1));
        #1; e = sb.pop_front(); o = obs(); total++;
        if (o !== e) begin bad++; $display("FAIL lu_rs: got %s want %s", fmt(o), fmt(e)); end
        bus.id_rs = 5'd9; bus.id_rt = 5'd10;
        sb.push_back(mk(32'd0, 32'd0, 32'd0, 6'd0, 5'd8, 1'b0, 1'b1, 1'b0));
        #1; e = sb.pop_front(); o = obs(); total++;
        if (o !== e) begin bad++; $display("FAIL lu_nomatch: got %s want %s", fmt(o), fmt(e)); end
        // load to r0 is not a hazard
        id_zero();
        bus.id_mem_read = 1'b1;
        tick();
        sb.push_back(mk(32'd0, 32'd0, 32'd0, 6'd0, 5'd0, 1'b0, 1'b1, 1'b0));
        #1; e = sb.pop_front(); o = obs(); total++;
        if (o !== e) begin bad++; $display("FAIL lu_r0: got %s want %s", fmt(o), fmt(e)); end
        // non-load producer is not a hazard
        id_zero();
        bus.id_dst = 5'd8; bus.id_reg_write = 1'b1;
        tick();
        bus.id_rt = 5'd8;
        sb.push_back(mk(32'd0, 32'd0, 32'd0, 6'd0, 5'd8, 1'b1, 1'b0, 1'b0));
        #1; e = sb.pop_front(); o = obs(); total++;
        if (o !== e) begin bad++; $display("FAIL lu_notload: got %s want %s", fmt(o), fmt(e)); end
    endtask

    task automatic test_stall_flush();
        exp_t held;
        id_zero();
        bus.id_rs = 5'd1; bus.id_rt = 5'd2; bus.id_rs_data = 32'hA1; bus.id_rt_data = 32'hB2;
        bus.id_dst = 5'd3; bus.id_alu_fun = 6'd5; bus.id_reg_write = 1'b1; bus.id_mem_write = 1'b1;
        held = mk(32'hA1, 32'hB2, 32'hB2, 6'd5, 5'd3, 1'b1, 1'b0, 1'b0);
        sb.push_back(held);
        tick();
        e = sb.pop_front(); o = obs(); total++;
        if (o !== e) begin bad++; $display("FAIL stall_load: got %s want %s", fmt(o), fmt(e)); end
        bus.stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.id_rs_data = 32'(1000 + i); bus.id_rt_data = 32'(2000 + i);
            bus.id_dst = 5'(10 + i); bus.id_alu_fun = 6'(20 + i);
            bus.id_rs = 5'(11 + i); bus.id_rt = 5'(14 + i); bus.id_reg_write = 1'b0;
            bus.id_mem_write = 1'b0;
            sb.push_back(held);
            tick();
            e = sb.pop_front(); o = obs(); total++;
            if (o !== e) begin bad++; $display("FAIL stall_hold%0d: got %s want %s", i, fmt(o), fmt(e)); end
        end
        total++;
        if (bus.ex_mem_write !== 1'b1) begin
            bad++; $display("FAIL stall_mw: got %b want 1", bus.ex_mem_write);
        end
        bus.flush = 1'b1;
        sb.push_back(mk(32'd0, 32'd0, 32'd0, 6'd0, 5'd0, 1'b0, 1'b0, 1'b0));
        tick();
        e = sb.pop_front(); o = obs(); total++;
        if (o !== e) begin bad++; $display("FAIL stall_flush: got %s want %s", fmt(o), fmt(e)); end
        total++;
        if (bus.ex_mem_write !== 1'b0) begin
            bad++; $display("FAIL flush_mw: got %b want 0", bus.ex_mem_write);
        end
        id_zero();
        bus.id_dst = 5'd5; bus.id_reg_write = 1'b1; bus.id_alu_fun = 6'd7; bus.id_rs_data = 32'h77;
        sb.push_back(mk(32'h77, 32'd0, 32'd0, 6'd7, 5'd5, 1'b1, 1'b0, 1'b0));
        tick();
        e = sb.pop_front(); o = obs(); total++;
        if (o !== e) begin bad++; $display("FAIL pre_rst: got %s want %s", fmt(o), fmt(e)); end
        reset = 1'b1; bus.flush = 1'b1; bus.stall = 1'b1;
        sb.push_back(mk(32'd0, 32'd0, 32'd0, 6'd0, 5'd0, 1'b0, 1'b0, 1'b0));
        tick();
        e = sb.pop_front(); o = obs(); total++;
        if (o !== e) begin bad++; $display("FAIL rst_all: got %s want %s", fmt(o), fmt(e)); end
        reset = 1'b0; bus.flush = 1'b0; bus.stall = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [31:0] rsd, rtd, imm;
        id_zero();
        for (int i = 0; i < 6; i++) begin
            rsd = 32'(i * 11 + 1); rtd = 32'(i * 7 + 2); imm = 32'(32'h1000 + i);
            bus.id_rs = 5'(i + 1); bus.id_rt = 5'(i + 10);
            bus.id_rs_data = rsd; bus.id_rt_data = rtd; bus.id_imm = imm;
            bus.id_dst = 5'(i + 1); bus.id_alu_fun = 6'(i); bus.id_alu_src2 = (i % 2) == 1;
            bus.id_reg_write = 1'b1;
            sb.push_back(mk(rsd, ((i % 2) == 1) ? imm : rtd, rtd, 6'(i), 5'(i + 1),
                            1'b1, 1'b0, 1'b0));
            tick();
            e = sb.pop_front(); o = obs(); total++;
            if (o !== e) begin bad++; $display("FAIL b2b%0d: got %s want %s", i, fmt(o), fmt(e)); end
        end
    endtask

    initial begin
        reset = 1'b1;
        id_zero();
        test_reset();
        test_capture();
        test_fwd_priority();
        test_shamt_imm();
        test_load_use();
        test_stall_flush();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
